imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the instruction memory write port and holds the core in reset until a checksummed image has been stored. This replaces hierarchical pokes into `instr_mem.mem` as the way programs enter the core.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- `clk`  input  1  single clock.
- `reset`  input  1  synchronous, active-low: the block is in reset when `reset` is 0, sampled on the rising edge of `clk`.
- `start`  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  input  1  byte available.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction-memory write strobe.
- `mem_addr`  output  ADDR_W  word address.
- `mem_wdata`  output  32  instruction word.
- `cpu_reset`  output  1  active-high reset to the core (drives `cpu.reset`).
- `busy`  output  1  load in progress.
- `done`  output  1  image loaded, checksum good.
- `err`  output  1  load aborted.

## Operation
- Stream format:
  - N_lo, N_hi: word count N, 16-bit little-endian.
  - 4·N instruction bytes, least-significant byte first.
  - One checksum byte equal to the XOR of every preceding byte of the frame, including the length bytes.
- A byte is accepted when `in_valid & in_ready`. `in_ready` depends only on state, never on `in_valid`.
- States and transitions:
  - IDLE: `start` → LEN_LO.
  - LEN_LO → LEN_HI on accept.
  - LEN_HI on accept:
    - N > DEPTH → ERR.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: after 4·N accepted bytes → CSUM.
  - CSUM on accept: match → DONE; mismatch → ERR.
  - DONE/ERR: `start` → LEN_LO, which clears the word index, byte lane and running checksum.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 otherwise.
- `busy` = 1 in LEN_LO through CSUM.
- `cpu_reset` = 0 only in DONE; 1 in every other state, including ERR.
- Word assembly:
  - Byte k of a word lands in bits [8k+7:8k].
  - On the 4th byte of a word, `mem_wdata` = the assembled word and `mem_addr` = the word index (0..N−1), with `mem_we` high for exactly one cycle.
  - The index wraps only through `start`; no write ever occurs at index ≥ N.
- `start` while `busy` is ignored.
- `mem_addr` and `mem_wdata` hold their last values between strobes.

## Timing
- Reset values (`reset` low on an edge): state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_reset` 1, `busy` 0, `done` 0, `err` 0.
- Reset mid-load discards the partial word, index and checksum. Memory contents already written are left untouched.
- `start` sampled on edge t → `busy`=1 and `in_ready`=1 from t+1.
- Throughput is one byte per cycle. Full-rate frame length = 3 + 4·N accept cycles.
- `mem_we` is registered: asserted in the cycle after the edge that accepts the word's 4th byte.
- The checksum byte is accepted on edge t:
  - Match: from t+1, `done`=1, `cpu_reset`=0, `busy`=0.
  - Mismatch: from t+1, `err`=1, `cpu_reset` stays 1.
- Oversize length: `err`=1 the cycle after the N_hi accept; no further bytes accepted.
- `start` on edge t in DONE: from t+1, `cpu_reset`=1, `done`=0.
- `done` and `err` are never 1 simultaneously.

## Structure
- Package `imem_loader_pkg`:
  - state enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - `LEN_BYTES` = 2;
  - `WORD_BYTES` = 4.
- Sub-module `word_packer`: 2-bit byte lane counter plus 32-bit shift/insert register. It emits `word_valid` with the assembled word and clears on loader restart or reset.
- The top level holds the FSM, the 16-bit N register, the word index, the running checksum and the output registers.

## Test plan
All scenarios use ADDR_W=8.
- Nominal load, `in_valid` held 1. Stream:
  - length bytes 04 00;
  - payload 93 00 50 00 13 01 A0 00 B3 81 20 00 33 82 20 40;
  - checksum B6.
  - Required: 4 `mem_we` pulses at addr 0..3 with data 00500093, 00A00113, 002081B3, 40208233; 19 accepts; `done`=1, `cpu_reset`=0 one cycle after the last accept.
- Same frame with checksum B7 → all 4 writes occur, then `err`=1, `cpu_reset` stays 1, `in_ready`=0, `done`=0.
- Frame 00 00 00 → `done`=1, zero `mem_we` pulses.
- Length 01 01 (N=257 > DEPTH) → `err`=1 after the 2nd accept, no `mem_we`, `in_ready`=0.
- Nominal frame with `in_valid` randomly deasserted for about 50% of cycles → identical writes and end state to the first scenario.
- Two stressed cases, each must end with correct writes and `done`=1:
  - `reset` low for one cycle after 6 data bytes, expecting all outputs at reset values, then `start` and a full nominal frame.
  - `start` pulsed mid-DATA (ignored), then `start` in DONE → `cpu_reset`=1 next cycle, followed by a reload.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - assembles little-endian bytes into 32-bit words
module word_packer
    import imem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      word_valid,
    output logic [8*WORD_BYTES-1:0]   word_data
);

    localparam int LANE_W = $clog2(WORD_BYTES);

    logic [LANE_W-1:0]             lane;
    logic [8*(WORD_BYTES-1)-1:0]   shreg;

    // The final byte is merged combinationally so the word is ready on its accept edge.
    assign word_valid = byte_valid && (lane == LANE_W'(WORD_BYTES - 1));
    assign word_data  = {byte_data, shreg};

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + 1'b1;
            shreg <= {byte_data, shreg[8*(WORD_BYTES-1)-1:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W:0]   DEPTH = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_t      state, state_n;
    logic [LEN_W-1:0]   n_len;
    logic [LEN_W-1:0]   n_new;
    logic [LEN_W-1:0]   wcnt;
    logic [7:0]         csum;
    logic               accept;
    logic               restart;
    logic               oversize;
    logic               last_word;
    logic               word_valid;
    logic [31:0]        word_data;

    assign accept    = in_valid && in_ready;
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);
    assign n_new     = {in_data, n_len[7:0]};
    assign oversize  = {1'b0, n_new} > DEPTH;
    assign last_word = (wcnt + 1'b1) == n_len;

    word_packer u_packer (
        .clk        (clk),
        .resetn     (reset),
        .clear      (restart),
        .byte_valid (accept && state == DATA),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_n = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_n = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (oversize)           state_n = ERR;
                    else if (n_new == '0)   state_n = CSUM;
                    else                    state_n = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_valid && last_word) state_n = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_n = (in_data == csum) ? DONE : ERR;
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_n = LEN_LO;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_n = LEN_LO;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            n_len     <= '0;
            wcnt      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_n;
            mem_we <= 1'b0;
            if (restart) begin
                wcnt <= '0;
                csum <= '0;
            end else if (accept) begin
                csum <= csum ^ in_data;
            end
            if (accept && state == LEN_LO) n_len[7:0]       <= in_data;
            if (accept && state == LEN_HI) n_len[LEN_W-1:8] <= in_data;
            // Only reachable in DATA with wcnt < N, so no write lands past the image.
            if (word_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= wcnt[ADDR_W-1:0];
                mem_wdata <= word_data;
                wcnt      <= wcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    logic [7:0]  nom [19] = '{8'h04, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0,
                              8'h00, 8'hB3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82, 8'h20, 8'h40, 8'hB6};
    logic [31:0] exp_w [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233};

    logic [ADDR_W-1:0] wa [$];
    logic [31:0]       wd [$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    always @(posedge clk) begin
        if (reset && in_valid && in_ready) n_acc <= n_acc + 1;
    end

    task send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%b required 1 (byte %h)", in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task send_nom(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) send_byte(nom[i], gaps);
    endtask

    task do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b err=%b required 0 0 00 00000000 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, in_ready, cpu_reset} !== 3'b001) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy/rdy/cpu_reset=%b required 001", {busy, in_ready, cpu_reset});
        end
    endtask

    task test_nominal;
        int base, a0;
        base = wa.size();
        a0   = n_acc;
        do_start;
        n_cmp++;
        if ({busy, in_ready, cpu_reset} !== 3'b111) begin
            n_bad++;
            $display("FAIL start_busy: busy/rdy/cpu_reset=%b required 111", {busy, in_ready, cpu_reset});
        end
        send_nom(0, 18, 1'b0);
        n_cmp++;
        if ({done, err, cpu_reset, busy, in_ready} !== 5'b10000) begin
            n_bad++;
            $display("FAIL nominal_end: done/err/cpu_reset/busy/rdy=%b required 10000", {done, err, cpu_reset, busy, in_ready});
        end
        n_cmp++;
        if (n_acc - a0 !== 19) begin
            n_bad++;
            $display("FAIL nominal_accepts: got %0d required 19", n_acc - a0);
        end
        n_cmp++;
        if (wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL nominal_wcount: got %0d required 4", wa.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
            n_cmp++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL nominal_write%0d: addr=%h data=%h required addr=%h data=%h", i, wa[base+i], wd[base+i], 8'(i), exp_w[i]);
            end
        end
    endtask

    task test_bad_csum;
        int base;
        base = wa.size();
        do_start;
        send_nom(0, 17, 1'b0);
        send_byte(8'hB7, 1'b0);
        n_cmp++;
        if ({done, err, cpu_reset, in_ready} !== 4'b0110) begin
            n_bad++;
            $display("FAIL bad_csum_end: done/err/cpu_reset/rdy=%b required 0110", {done, err, cpu_reset, in_ready});
        end
        n_cmp++;
        if (wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL bad_csum_wcount: got %0d required 4", wa.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
            n_cmp++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL bad_csum_write%0d: addr=%h data=%h required addr=%h data=%h", i, wa[base+i], wd[base+i], 8'(i), exp_w[i]);
            end
        end
    endtask

    task test_empty;
        int base;
        base = wa.size();
        do_start;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        n_cmp++;
        if ({done, err, cpu_reset, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL empty_end: done/err/cpu_reset/busy=%b required 1000", {done, err, cpu_reset, busy});
        end
        n_cmp++;
        if (wa.size() - base !== 0) begin
            n_bad++;
            $display("FAIL empty_wcount: got %0d required 0", wa.size() - base);
        end
    endtask

    task test_oversize;
        int base, a0;
        base = wa.size();
        a0   = n_acc;
        do_start;
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        n_cmp++;
        if ({err, in_ready, done, cpu_reset, busy} !== 5'b10010) begin
            n_bad++;
            $display("FAIL oversize_err: err/rdy/done/cpu_reset/busy=%b required 10010", {err, in_ready, done, cpu_reset, busy});
        end
        in_valid = 1'b1;
        in_data  = 8'h11;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc - a0 !== 2 || wa.size() - base !== 0) begin
            n_bad++;
            $display("FAIL oversize_quiet: accepts=%0d writes=%0d required 2 and 0", n_acc - a0, wa.size() - base);
        end
    endtask

    task test_gaps;
        int base, a0;
        base = wa.size();
        a0   = n_acc;
        do_start;
        send_nom(0, 18, 1'b1);
        n_cmp++;
        if ({done, err, cpu_reset, busy} !== 4'b1000 || n_acc - a0 !== 19) begin
            n_bad++;
            $display("FAIL gaps_end: done/err/cpu_reset/busy=%b accepts=%0d required 1000 and 19", {done, err, cpu_reset, busy}, n_acc - a0);
        end
        n_cmp++;
        if (wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL gaps_wcount: got %0d required 4", wa.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
            n_cmp++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL gaps_write%0d: addr=%h data=%h required addr=%h data=%h", i, wa[base+i], wd[base+i], 8'(i), exp_w[i]);
            end
        end
    endtask

    task test_reset_mid;
        int base;
        do_start;
        send_nom(0, 7, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_values: rdy=%b we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b err=%b required 0 0 00 00000000 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err);
        end
        reset = 1'b1;
        base  = wa.size();
        do_start;
        send_nom(0, 18, 1'b0);
        n_cmp++;
        if ({done, err, cpu_reset} !== 3'b100 || wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL mid_reset_reload: done/err/cpu_reset=%b writes=%0d required 100 and 4", {done, err, cpu_reset}, wa.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
            n_cmp++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL mid_reset_write%0d: addr=%h data=%h required addr=%h data=%h", i, wa[base+i], wd[base+i], 8'(i), exp_w[i]);
            end
        end
    endtask

    task test_restart;
        int base;
        base = wa.size();
        do_start;
        send_nom(0, 6, 1'b0);
        start = 1'b1;
        send_byte(nom[7], 1'b0);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored: busy=%b required 1", busy);
        end
        send_nom(8, 18, 1'b0);
        n_cmp++;
        if ({done, err} !== 2'b10 || wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL restart_first: done/err=%b writes=%0d required 10 and 4", {done, err}, wa.size() - base);
        end
        base = wa.size();
        do_start;
        n_cmp++;
        if ({cpu_reset, done, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL done_restart: cpu_reset/done/busy=%b required 101", {cpu_reset, done, busy});
        end
        send_nom(0, 18, 1'b0);
        n_cmp++;
        if ({done, cpu_reset} !== 2'b10 || wa.size() - base !== 4) begin
            n_bad++;
            $display("FAIL reload_end: done/cpu_reset=%b writes=%0d required 10 and 4", {done, cpu_reset}, wa.size() - base);
        end
        for (int i = 0; i < 4 && base + i < wa.size(); i++) begin
            n_cmp++;
            if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL reload_write%0d: addr=%h data=%h required addr=%h data=%h", i, wa[base+i], wd[base+i], 8'(i), exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_bad_csum;
        test_empty;
        test_oversize;
        test_gaps;
        test_reset_mid;
        test_restart;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
